// File: rtl/mac_pkg.sv
// Shared definitions for the mac result path: widths, the data-type tag
// encoding and the result-collector FSM state type.
package mac_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 8;

  localparam logic TYPE_FP16 = 1'b1;
  localparam logic TYPE_INT  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter and a registered head entry.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo
  import mac_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF + 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [WIDTH-1:0]         o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;

  logic w_doPop;
  logic w_doPush;

  assign o_full   = (r_level == LW'(DEPTH));
  assign o_empty  = (r_level == '0);
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_level = r_level;
  assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/mac_result_collector.sv
// Collects mac results for one configured job, tags them with the job type,
// marks the final word and replays them on a ready/valid stream.
module mac_result_collector
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   config_en,
  input  logic                   float_int,
  input  logic [CNT_W-1:0]       data_num,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_float,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   job_done,
  output logic                   overflow,
  output logic                   stray
);

  state_t             r_state;
  state_t             w_nextState;
  logic               r_float;
  logic [CNT_W-1:0]   r_num;
  logic [CNT_W-1:0]   r_count;
  logic               r_jobDone;
  logic               r_overflow;
  logic               r_stray;

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_lastPush;
  logic               w_full;
  logic               w_empty;
  logic [DATA_W+1:0]  w_head;

  assign w_pop      = out_valid & out_ready;
  assign w_lastPush = ((r_count + CNT_W'(1)) == r_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (config_en) begin
          w_accept = 1'b1;
          if (data_num != '0) begin
            w_nextState = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (in_valid) begin
          w_push = 1'b1;
          if (w_lastPush) begin
            w_nextState = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Only the word tagged last closes the job; a dropped last word leaves it open.
        if (w_pop && out_last) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_float    <= 1'b0;
      r_num      <= '0;
      r_count    <= '0;
      r_jobDone  <= 1'b0;
      r_overflow <= 1'b0;
      r_stray    <= 1'b0;
    end else begin
      r_jobDone <= 1'b0;
      if (w_accept) begin
        r_float   <= float_int;
        r_num     <= data_num;
        r_count   <= '0;
        r_jobDone <= (data_num == '0);
      end
      // The count advances even for a dropped word so the job still ends on time.
      if (w_push) begin
        r_count <= r_count + CNT_W'(1);
        if (w_full && !w_pop) begin
          r_overflow <= 1'b1;
        end
      end
      if (in_valid && (r_state != ST_COLLECT)) begin
        r_stray <= 1'b1;
      end
      if ((r_state == ST_DRAIN) && w_pop && out_last) begin
        r_jobDone <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({w_lastPush, r_float, in_data}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level),
    .o_head  (w_head)
  );

  assign out_valid = ~w_empty;
  assign out_last  = w_head[DATA_W+1];
  assign out_float = w_head[DATA_W];
  assign out_data  = w_head[DATA_W-1:0];
  assign job_done  = r_jobDone;
  assign overflow  = r_overflow;
  assign stray     = r_stray;

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector: directed job scenarios plus
// random traffic, compared every cycle against a transaction-level model.
module tb_mac_result_collector;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              config_en;
  logic              float_int;
  logic [CNT_W-1:0]  data_num;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_float;
  logic              out_last;
  logic [3:0]        level;
  logic              job_done;
  logic              overflow;
  logic              stray;

  int testCount = 0;
  int failCount = 0;

  // Model: a job is open while results are still expected, or awaiting the
  // consumer to take the word marked last.
  logic [17:0] mQueue[$];
  bit          mCollecting;
  bit          mAwaitLast;
  int          mSeen;
  int          mExpect;
  bit          mFloat;
  bit          mDone;
  bit          mOverflow;
  bit          mStray;

  always #5 clk = ~clk;

  mac_result_collector #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .config_en (config_en),
    .float_int (float_int),
    .data_num  (data_num),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_float (out_float),
    .out_last  (out_last),
    .level     (level),
    .job_done  (job_done),
    .overflow  (overflow),
    .stray     (stray)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelClear();
    mQueue.delete();
    mCollecting = 0;
    mAwaitLast  = 0;
    mSeen       = 0;
    mExpect     = 0;
    mFloat      = 0;
    mDone       = 0;
    mOverflow   = 0;
    mStray      = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit          doPop;
    bit          poppedLast;
    bit          wasCollecting;
    bit          wasAwaiting;
    bit          wasIdle;
    bit          nextDone;
    bit          isLast;
    int          sizeBefore;
    sizeBefore    = mQueue.size();
    doPop         = (sizeBefore > 0) && out_ready;
    poppedLast    = doPop && mQueue[0][17];
    wasCollecting = mCollecting;
    wasAwaiting   = mAwaitLast;
    wasIdle       = !mCollecting && !mAwaitLast;
    nextDone      = 0;
    if (doPop) void'(mQueue.pop_front());
    if (in_valid && !wasCollecting) mStray = 1;
    if (wasIdle && config_en) begin
      mFloat  = float_int;
      mExpect = int'(data_num);
      mSeen   = 0;
      if (data_num == 0) nextDone = 1;
      else mCollecting = 1;
    end
    if (wasCollecting && in_valid) begin
      mSeen++;
      isLast = (mSeen == mExpect);
      if (sizeBefore == DEPTH && !doPop) mOverflow = 1;
      else mQueue.push_back({isLast, mFloat, in_data});
      if (isLast) begin
        mCollecting = 0;
        mAwaitLast  = 1;
      end
    end
    if (wasAwaiting && poppedLast) begin
      mAwaitLast = 0;
      nextDone   = 1;
    end
    mDone = nextDone;
  endtask

  task automatic compareAll();
    checkOutput("out_valid", out_valid, mQueue.size() != 0);
    checkOutput("level", level, mQueue.size());
    checkOutput("job_done", job_done, mDone);
    checkOutput("overflow", overflow, mOverflow);
    checkOutput("stray", stray, mStray);
    if (mQueue.size() != 0) begin
      checkOutput("head", {out_last, out_float, out_data}, mQueue[0]);
    end
  endtask

  task automatic applyStimulus(input logic cfg, input logic fi, input logic [7:0] dn,
                               input logic iv, input logic [15:0] id, input logic ordy);
    config_en = cfg;
    float_int = fi;
    data_num  = dn;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic applyReset();
    rst       = 1'b1;
    config_en = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelClear();
    compareAll();
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_float", out_float, 0);
    checkOutput("rst_out_last", out_last, 0);
  endtask

  task automatic idleCycles(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, ordy);
  endtask

  logic [15:0] basicWords [4];

  initial begin
    rst = 1'b1; config_en = 0; float_int = 0; data_num = 0;
    in_valid = 0; in_data = 0; out_ready = 0;
    modelClear();
    applyReset();

    // Basic FP16 job of four words with the consumer always ready.
    basicWords[0] = 16'h3C00; basicWords[1] = 16'h4000;
    basicWords[2] = 16'h4200; basicWords[3] = 16'h4400;
    applyStimulus(1, 1, 4, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, basicWords[i], 1);
      checkOutput("basic_word", {out_last, out_float, out_data}, {(i == 3), 1'b1, basicWords[i]});
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("basic_done", job_done, 1);
    idleCycles(2, 1);

    // Backpressure: ten words into eight slots, the last two are lost.
    applyStimulus(1, 1, 10, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 16'($urandom), 0);
    checkOutput("bp_level_sat", level, 8);
    checkOutput("bp_overflow", overflow, 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      if (i < 8) checkOutput("bp_no_last", out_last & out_valid, 0);
    end
    idleCycles(4, 1);
    checkOutput("bp_no_done", job_done, 0);
    applyReset();

    // Full FIFO with simultaneous push and pop.
    applyStimulus(1, 0, 13, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 16'($urandom), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 16'($urandom), 1);
      checkOutput("full_level", level, 8);
    end
    checkOutput("full_no_overflow", overflow, 0);
    idleCycles(10, 1);

    // Stray word in IDLE, then a zero-length job.
    applyStimulus(0, 0, 0, 1, 16'hBEEF, 1);
    checkOutput("stray_flag", stray, 1);
    checkOutput("stray_level", level, 0);
    applyStimulus(1, 1, 0, 0, 0, 1);
    checkOutput("zero_done", job_done, 1);
    checkOutput("zero_out_valid", out_valid, 0);
    idleCycles(2, 1);

    // Reset in the middle of a job, then a clean INT job.
    applyStimulus(1, 1, 6, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 16'($urandom), 0);
    applyReset();
    checkOutput("rst_level", level, 0);
    checkOutput("rst_stray", stray, 0);
    applyStimulus(1, 0, 2, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 16'h0011, 1);
    checkOutput("int_float", out_float, 0);
    applyStimulus(0, 0, 0, 1, 16'h0022, 1);
    checkOutput("int_last", out_last, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("int_done", job_done, 1);

    // Longest job: 255 words without counter wrap.
    applyStimulus(1, 1, 255, 0, 0, 1);
    for (int i = 0; i < 255; i++) applyStimulus(0, 0, 0, 1, 16'(i), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("long_done", job_done, 1);

    // Random traffic; a job stuck after overflow is recovered with reset.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, 1'($urandom), 8'($urandom_range(0, 12)),
                    $urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 7);
      if (mOverflow && mAwaitLast && mQueue.size() == 0) applyReset();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
